// File: rtl/vgather_if.sv
// vgather_if: scalar pair input stream plus packed vector output stream.
// The optional in_last wire exists only when VGATHER_FLUSH_EN is defined.
//
// Handshake rule for both streams: a beat transfers on a rising edge where
// valid and ready are both 1; while valid=1 and ready=0 the producer keeps
// valid high and its data unchanged; ready may depend on state only, never
// on the same-cycle valid.
interface vgather_if #(
  parameter int VECTOR_SIZE = 16,
  parameter int INT_SIZE    = 16
);
  logic                                   in_valid;
  logic                                   in_ready;
  logic [INT_SIZE-1:0]                    in_a;
  logic [INT_SIZE-1:0]                    in_x;
`ifdef VGATHER_FLUSH_EN
  logic                                   in_last;
`endif
  logic                                   out_valid;
  logic                                   out_ready;
  logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]   out_a;
  logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]   out_x;
  logic [$clog2(VECTOR_SIZE+1)-1:0]       fill_count;

`ifdef VGATHER_FLUSH_EN
  // Upstream producer / downstream consumer side (testbench or neighbours).
  modport master (
    output in_valid, in_a, in_x, in_last, out_ready,
    input  in_ready, out_valid, out_a, out_x, fill_count
  );
  // The gather block itself.
  modport slave (
    input  in_valid, in_a, in_x, in_last, out_ready,
    output in_ready, out_valid, out_a, out_x, fill_count
  );
`else
  modport master (
    output in_valid, in_a, in_x, out_ready,
    input  in_ready, out_valid, out_a, out_x, fill_count
  );
  modport slave (
    input  in_valid, in_a, in_x, out_ready,
    output in_ready, out_valid, out_a, out_x, fill_count
  );
`endif
endinterface

// File: rtl/vgather.sv
// vgather: packs VECTOR_SIZE scalar (a, x) pairs into one packed lane vector
// and issues it as a single beat. A fill buffer collects lanes while the
// output register holds the previous vector, so input keeps flowing while a
// finished vector waits downstream.
// Optional feature macro: VGATHER_FLUSH_EN (adds in_last to close a vector
// early; lanes above the closing lane are zero-filled).
module vgather #(
  parameter int VECTOR_SIZE = 16,
  parameter int INT_SIZE    = 16
) (
  input  logic      clock,
  input  logic      reset,
  vgather_if.slave  bus,
  output logic      state_o   // debug: 0 = FILL, 1 = FULL
);

  localparam int IW = $clog2(VECTOR_SIZE);
  localparam int CW = $clog2(VECTOR_SIZE + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(VECTOR_SIZE - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  typedef logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] vec_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  vec_t          fill_a_q, fill_a_d;
  vec_t          fill_x_q, fill_x_d;
  vec_t          out_a_q, out_a_d;
  vec_t          out_x_q, out_x_d;
  logic          out_valid_q, out_valid_d;

  logic          in_ready_w;
  logic          accept_w;
  logic          slot_free_w;
  logic          close_w;
  vec_t          closed_a_w;
  vec_t          closed_x_w;

  // Input is taken only in FILL and never while reset is asserted.
  assign in_ready_w  = (state_q == S_FILL) && !reset;
  assign accept_w    = bus.in_valid && in_ready_w;
  // Output slot can take a new vector if empty or being drained this cycle.
  assign slot_free_w = !out_valid_q || bus.out_ready;

`ifdef VGATHER_FLUSH_EN
  assign close_w = (idx_q == LAST_IDX) || bus.in_last;
`else
  assign close_w = (idx_q == LAST_IDX);
`endif

  // Fill buffer with the current pair merged in at lane idx; when this pair
  // closes the vector, every lane above it is zeroed.
  always_comb begin
    closed_a_w = fill_a_q;
    closed_x_w = fill_x_q;
    for (int k = 0; k < VECTOR_SIZE; k++) begin
      if (k == int'(idx_q)) begin
        closed_a_w[k] = bus.in_a;
        closed_x_w[k] = bus.in_x;
      end else if (k > int'(idx_q) && close_w) begin
        closed_a_w[k] = '0;
        closed_x_w[k] = '0;
      end
    end
  end

  // Next-state: lane collection, vector issue and the FULL stall.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fill_a_d    = fill_a_q;
    fill_x_d    = fill_x_q;
    out_a_d     = out_a_q;
    out_x_d     = out_x_q;
    out_valid_d = out_valid_q;

    // A transfer empties the slot; data is held. A load below overrides.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_FILL: begin
        if (accept_w) begin
          fill_a_d = closed_a_w;
          fill_x_d = closed_x_w;
          if (close_w) begin
            idx_d = '0;
            if (slot_free_w) begin
              out_a_d     = closed_a_w;
              out_x_d     = closed_x_w;
              out_valid_d = 1'b1;
            end else begin
              state_d = S_FULL;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FULL: begin
        if (slot_free_w) begin
          out_a_d     = fill_a_q;
          out_x_d     = fill_x_q;
          out_valid_d = 1'b1;
          state_d     = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // State and datapath registers; reset discards partial and pending data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_FILL;
      idx_q       <= '0;
      fill_a_q    <= '0;
      fill_x_q    <= '0;
      out_a_q     <= '0;
      out_x_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fill_a_q    <= fill_a_d;
      fill_x_q    <= fill_x_d;
      out_a_q     <= out_a_d;
      out_x_q     <= out_x_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_a      = out_a_q;
  assign bus.out_x      = out_x_q;
  assign bus.fill_count = (state_q == S_FULL) ? CW'(VECTOR_SIZE) : CW'(idx_q);
  assign state_o        = (state_q == S_FULL);

endmodule

// File: tb/tb_vgather.sv
// tb_vgather: directed bench for vgather with VECTOR_SIZE=4, INT_SIZE=16.
module tb_vgather;

  localparam int VS = 4;
  localparam int IS = 16;

  logic clock = 1'b0;
  logic reset;
  logic state_o;

  vgather_if #(.VECTOR_SIZE(VS), .INT_SIZE(IS)) bus ();

  vgather #(.VECTOR_SIZE(VS), .INT_SIZE(IS)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int pushes = 0;
  logic [2*VS*IS-1:0] exp_q[$];
  logic rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [VS-1:0][IS-1:0] a, input logic [VS-1:0][IS-1:0] x);
    exp_q.push_back({a, x});
    pushes++;
  endtask

  // Every output transfer is compared with the oldest expected vector.
  always @(negedge clock) begin
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      beats++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 128'({bus.out_a, bus.out_x}), 128'(0));
      end else begin
        chk("beat", 128'({bus.out_a, bus.out_x}), 128'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  int stalls = 0;

  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one pair and wait until it is accepted (bounded).
  task automatic send(input logic [IS-1:0] a, input logic [IS-1:0] x);
    logic acc;
    int n;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_x     = x;
    n = 0;
    do begin
      acc = bus.in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (n > 1) stalls++;
    chk("accept", 128'(acc), 128'(1));
  endtask

  // ---------------- stimulus ----------------
  logic [VS-1:0][IS-1:0] cur_a, cur_x;
  int beats_before;

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_x      = '0;
    bus.out_ready = 1'b0;
`ifdef VGATHER_FLUSH_EN
    bus.in_last   = 1'b0;
`endif
    tick();
    tick();
    // reset state
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", 128'({bus.out_a, bus.out_x}), 128'(0));
    chk("rst_fill_count", 128'(bus.fill_count), 128'(0));
    chk("rst_state", 128'(state_o), 128'(0));
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1));

    // Single vector, downstream always ready.
    bus.out_ready = 1'b1;
    push_exp(64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005);
    send(16'd1, 16'd5);
    send(16'd2, 16'd6);
    chk("t1_fill_count_2", 128'(bus.fill_count), 128'(2));
    send(16'd3, 16'd7);
    send(16'd4, 16'd8);
    bus.in_valid = 1'b0;
    chk("t1_out_valid", 128'(bus.out_valid), 128'(1));
    chk("t1_out_a", 128'(bus.out_a), 128'(64'h0004_0003_0002_0001));
    chk("t1_out_x", 128'(bus.out_x), 128'(64'h0008_0007_0006_0005));
    chk("t1_fill_count_0", 128'(bus.fill_count), 128'(0));
    tick();
    chk("t1_out_valid_drop", 128'(bus.out_valid), 128'(0));

    // Downstream stalled: second vector parks in FULL, then issues back-to-back.
    bus.out_ready = 1'b0;
    push_exp(64'h0014_0013_0012_0011, 64'h0024_0023_0022_0021);
    push_exp(64'h0018_0017_0016_0015, 64'h0028_0027_0026_0025);
    for (int i = 0; i < 8; i++) send(IS'(16'h11 + i), IS'(16'h21 + i));
    bus.in_valid = 1'b0;
    chk("t2_in_ready_full", 128'(bus.in_ready), 128'(0));
    chk("t2_fill_count_full", 128'(bus.fill_count), 128'(4));
    chk("t2_state_full", 128'(state_o), 128'(1));
    chk("t2_out_a_v1", 128'(bus.out_a), 128'(64'h0014_0013_0012_0011));
    tick();
    tick();
    chk("t2_hold_valid", 128'(bus.out_valid), 128'(1));
    chk("t2_hold_data", 128'({bus.out_a, bus.out_x}),
        128'({64'h0014_0013_0012_0011, 64'h0024_0023_0022_0021}));
    chk("t2_hold_in_ready", 128'(bus.in_ready), 128'(0));
    bus.out_ready = 1'b1;
    tick();
    chk("t2_b2b_valid", 128'(bus.out_valid), 128'(1));
    chk("t2_b2b_data", 128'({bus.out_a, bus.out_x}),
        128'({64'h0018_0017_0016_0015, 64'h0028_0027_0026_0025}));
    chk("t2_in_ready_back", 128'(bus.in_ready), 128'(1));
    chk("t2_fill_count_0", 128'(bus.fill_count), 128'(0));
    tick();
    chk("t2_out_valid_drop", 128'(bus.out_valid), 128'(0));

    // Continuous stream of 12 pairs: 3 beats, no input stall.
    stalls = 0;
    beats_before = beats;
    for (int i = 0; i < 12; i++) begin
      cur_a[i % 4] = IS'(100 + i);
      cur_x[i % 4] = IS'(200 + i);
      if (i % 4 == 3) push_exp(cur_a, cur_x);
      send(IS'(100 + i), IS'(200 + i));
      if (i % 4 == 3) begin
        chk("t3_valid_after_4th", 128'(bus.out_valid), 128'(1));
        chk("t3_data", 128'({bus.out_a, bus.out_x}), 128'({cur_a, cur_x}));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    chk("t3_out_valid_drop", 128'(bus.out_valid), 128'(0));
    chk("t3_no_stalls", 128'(stalls), 128'(0));
    chk("t3_beats", 128'(beats - beats_before), 128'(3));

    // Reset mid-fill discards the partial vector.
    send(16'h50, 16'h60);
    send(16'h51, 16'h61);
    bus.in_valid = 1'b0;
    chk("t4_fill_count_2", 128'(bus.fill_count), 128'(2));
    reset = 1'b1;
    tick();
    chk("t4_rst_fill_count", 128'(bus.fill_count), 128'(0));
    chk("t4_rst_in_ready", 128'(bus.in_ready), 128'(0));
    chk("t4_rst_out_valid", 128'(bus.out_valid), 128'(0));
    reset = 1'b0;
    tick();
    push_exp(64'h000c_000b_000a_0009, 64'h0010_000f_000e_000d);
    for (int i = 0; i < 4; i++) send(IS'(9 + i), IS'(13 + i));
    bus.in_valid = 1'b0;
    chk("t4_out_valid", 128'(bus.out_valid), 128'(1));
    chk("t4_data", 128'({bus.out_a, bus.out_x}),
        128'({64'h000c_000b_000a_0009, 64'h0010_000f_000e_000d}));
    tick();

`ifdef VGATHER_FLUSH_EN
    // Early close at lane 1 zero-fills lanes 2..3; next pair starts at lane 0.
    push_exp(64'h0000_0000_0002_0007, 64'h0000_0000_0009_0003);
    bus.in_last = 1'b0;
    send(16'd7, 16'd3);
    bus.in_last = 1'b1;
    send(16'd2, 16'd9);
    bus.in_last = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_flush_valid", 128'(bus.out_valid), 128'(1));
    chk("t5_flush_data", 128'({bus.out_a, bus.out_x}),
        128'({64'h0000_0000_0002_0007, 64'h0000_0000_0009_0003}));
    chk("t5_fill_count_0", 128'(bus.fill_count), 128'(0));
    tick();
    push_exp(64'h0004_0003_0002_0001, 64'h000e_000d_000c_000b);
    for (int i = 0; i < 4; i++) send(IS'(1 + i), IS'(11 + i));
    bus.in_valid = 1'b0;
    chk("t5_next_data", 128'({bus.out_a, bus.out_x}),
        128'({64'h0004_0003_0002_0001, 64'h000e_000d_000c_000b}));
    tick();
`endif

    // Sparse input with random downstream stalls; the monitor checks order.
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cur_a[i % 4] = IS'($urandom_range(0, 65535));
      cur_x[i % 4] = IS'($urandom_range(0, 65535));
      if (i % 4 == 3) push_exp(cur_a, cur_x);
      send(cur_a[i % 4], cur_x[i % 4]);
      bus.in_valid = 1'b0;
      tick();
    end
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) tick();
    chk("t6_queue_empty", 128'(exp_q.size()), 128'(0));
    chk("t6_beats_total", 128'(beats), 128'(pushes));
    chk("t6_out_valid_idle", 128'(bus.out_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
